exp_time_ctrl_rpt: RTL

//  Parametrised exposure-time controller for the camera control path. Turns the user

---
 rtl/exp_time_ctrl_rpt.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/exp_time_ctrl_rpt.sv
// Exposure-time controller: press/hold-to-repeat stepping into a shadow value, committed while idle.
// Optional build macro EXP_WRAP_EN: a fresh press at a limit wraps to the opposite limit.
module exp_time_ctrl_rpt #(
   parameter int W        = 5,
   parameter int T_MIN    = 2,
   parameter int T_MAX    = 30,
   parameter int T_RST    = 10,
   parameter int STEP     = 1,
   parameter int HOLD_CYC = 500,
   parameter int RPT_CYC  = 100
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Exp_increase,
   input  logic         Exp_decrease,
   input  logic         Exp_busy,
   output logic [W-1:0] Exp_time,
   output logic         Exp_update,
   output logic         Exp_pending,
   output logic         At_min,
   output logic         At_max
);

   localparam int MAXC = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYC - 1);
   localparam logic [W:0]    STEP_X    = (W+1)'(STEP);
   localparam logic [W:0]    MAX_X     = (W+1)'(T_MAX);
   localparam logic [W:0]    MIN_X     = (W+1)'(T_MIN);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [W-1:0]  shadow_reg, shadow_next;
   logic          dir_reg, dir_next;      // 1 = increasing
   logic          prev_inc_reg, prev_dec_reg;
   logic [W-1:0]  exp_time_reg;
   logic          update_reg;

   logic          cmd_inc, cmd_dec, rise_inc, rise_dec;
   logic          step_en, step_up;
   logic [W:0]    sum_ext;
   logic [W-1:0]  inc_val, dec_val;

   assign cmd_inc  = Exp_increase & ~Exp_decrease;
   assign cmd_dec  = Exp_decrease & ~Exp_increase;
   assign rise_inc = cmd_inc & ~prev_inc_reg;
   assign rise_dec = cmd_dec & ~prev_dec_reg;

   // Saturating step results, evaluated one bit wider so nothing wraps.
   assign sum_ext = {1'b0, shadow_reg} + STEP_X;
   assign inc_val = (sum_ext > MAX_X) ? W'(T_MAX) : sum_ext[W-1:0];
   assign dec_val = ({1'b0, shadow_reg} < (MIN_X + STEP_X)) ? W'(T_MIN) : shadow_reg - W'(STEP);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dir_next   = dir_reg;
      step_en    = 1'b0;
      step_up    = dir_reg;
      if (Exp_increase && Exp_decrease) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (rise_inc || rise_dec) begin
                  step_en    = 1'b1;
                  step_up    = cmd_inc;
                  dir_next   = cmd_inc;
                  cnt_next   = '0;
                  state_next = HOLD;
               end
            end
            default: begin
               if (!cmd_inc && !cmd_dec) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cmd_inc != dir_reg) begin
                  // Other button alone: treat as a fresh press in the new direction.
                  step_en    = 1'b1;
                  step_up    = cmd_inc;
                  dir_next   = cmd_inc;
                  cnt_next   = '0;
                  state_next = HOLD;
               end else if (cnt_reg == ((state_reg == HOLD) ? HOLD_LAST : RPT_LAST)) begin
                  step_en    = 1'b1;
                  cnt_next   = '0;
                  state_next = REPEAT;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         endcase
      end

      shadow_next = shadow_reg;
      if (step_en) begin
`ifdef EXP_WRAP_EN
         if (state_reg == IDLE && step_up && shadow_reg == W'(T_MAX))
            shadow_next = W'(T_MIN);
         else if (state_reg == IDLE && !step_up && shadow_reg == W'(T_MIN))
            shadow_next = W'(T_MAX);
         else
            shadow_next = step_up ? inc_val : dec_val;
`else
         shadow_next = step_up ? inc_val : dec_val;
`endif
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         dir_reg      <= 1'b0;
         prev_inc_reg <= 1'b0;
         prev_dec_reg <= 1'b0;
         shadow_reg   <= W'(T_RST);
         exp_time_reg <= W'(T_RST);
         update_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         dir_reg      <= dir_next;
         prev_inc_reg <= cmd_inc;
         prev_dec_reg <= cmd_dec;
         shadow_reg   <= shadow_next;
         // Commit only between exposures, and only when the value really moves.
         if (!Exp_busy && shadow_next != exp_time_reg) begin
            exp_time_reg <= shadow_next;
            update_reg   <= 1'b1;
         end else begin
            update_reg   <= 1'b0;
         end
      end
   end

   assign Exp_time    = exp_time_reg;
   assign Exp_update  = update_reg;
   assign Exp_pending = (shadow_reg != exp_time_reg);
   assign At_min      = (shadow_reg == W'(T_MIN));
   assign At_max      = (shadow_reg == W'(T_MAX));

endmodule
